// File: rtl/fp_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : fp_div_seq
// Purpose  : Issue/sequencing stage in front of the multi-cycle FP divider.
//            Accepts an IEEE-754 single-precision A/B pair (result = A/B),
//            resolves special operands locally in one cycle, and otherwise
//            launches the iterative divider, waits for it with a stale-ready
//            guard and a timeout, and returns a one-cycle result pulse.
// Ports    : clk, rst_n                  - clock, synchronous active-low reset
//            req_valid/req_ready         - operand handshake (ready only in IDLE)
//            op_a, op_b                  - dividend, divisor
//            div_start, div_a, div_b     - divider launch pulse and operands
//            div_c, div_ready            - divider quotient and done level
//            res_valid, res_data         - result pulse and held result
//            flag_invalid/divzero/timeout- exception flags, valid with res_valid
//            busy                        - operation in flight
// Revision : 1.0 - initial release
// ============================================================================
module fp_div_seq #(
   parameter int unsigned DIV_GUARD = 2,
   parameter int unsigned TIMEOUT   = 64,
   parameter logic [31:0] QNAN      = 32'h7FC00000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        div_start,
   output logic [31:0] div_a,
   output logic [31:0] div_b,
   input  logic [31:0] div_c,
   input  logic        div_ready,
   output logic        res_valid,
   output logic [31:0] res_data,
   output logic        flag_invalid,
   output logic        flag_divzero,
   output logic        flag_timeout,
   output logic        busy
);

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_ISSUE = 2'd1;
   localparam logic [1:0] c_ST_WAIT  = 2'd2;
   localparam logic [1:0] c_ST_DONE  = 2'd3;

   // Guard counts DIV_GUARD..0; timeout counts 0..TIMEOUT-1 and aborts on the
   // cycle that would take it to TIMEOUT.
   localparam int unsigned      c_GW         = (DIV_GUARD > 0) ? $clog2(DIV_GUARD + 1) : 1;
   localparam int unsigned      c_TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_GW-1:0]  c_GUARD_LOAD = c_GW'(DIV_GUARD);
   localparam logic [c_GW-1:0]  c_GUARD_ONE  = c_GW'(1);
   localparam logic [c_TW-1:0]  c_TMO_LAST   = c_TW'(TIMEOUT - 1);
   localparam logic [c_TW-1:0]  c_TMO_ONE    = c_TW'(1);

   logic [1:0]      r_state;
   logic [c_GW-1:0] r_guard;
   logic [c_TW-1:0] r_tmo;
   logic [31:0]     r_div_a;
   logic [31:0]     r_div_b;
   logic [31:0]     r_res_data;
   logic            r_flag_invalid;
   logic            r_flag_divzero;
   logic            r_flag_timeout;

   // ------------------------------------------------------------------------
   // Operand classification
   // ------------------------------------------------------------------------
   logic w_a_exp_max, w_a_exp_zero, w_a_frac_nz;
   logic w_b_exp_max, w_b_exp_zero, w_b_frac_nz;
   logic w_a_nan, w_a_inf, w_a_zero;
   logic w_b_nan, w_b_inf, w_b_zero;
   logic w_sign;

   assign w_a_exp_max  = &op_a[30:23];
   assign w_a_exp_zero = ~|op_a[30:23];
   assign w_a_frac_nz  = |op_a[22:0];
   assign w_b_exp_max  = &op_b[30:23];
   assign w_b_exp_zero = ~|op_b[30:23];
   assign w_b_frac_nz  = |op_b[22:0];

   assign w_a_nan  = w_a_exp_max  &  w_a_frac_nz;
   assign w_a_inf  = w_a_exp_max  & ~w_a_frac_nz;
   assign w_a_zero = w_a_exp_zero & ~w_a_frac_nz;
   assign w_b_nan  = w_b_exp_max  &  w_b_frac_nz;
   assign w_b_inf  = w_b_exp_max  & ~w_b_frac_nz;
   assign w_b_zero = w_b_exp_zero & ~w_b_frac_nz;
   assign w_sign   = op_a[31] ^ op_b[31];

   logic        w_special;
   logic [31:0] w_spec_res;
   logic        w_spec_invalid;
   logic        w_spec_divzero;

   // Each branch relies on the earlier ones having excluded NaN and the
   // invalid pairs, so e.g. "a_inf" here already implies b finite.
   always_comb begin
      w_special      = 1'b1;
      w_spec_res     = QNAN;
      w_spec_invalid = 1'b0;
      w_spec_divzero = 1'b0;
      if (w_a_nan || w_b_nan) begin
         w_spec_invalid = 1'b1;
      end else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
         w_spec_invalid = 1'b1;
      end else if (w_a_inf) begin
         w_spec_res = {w_sign, 8'hFF, 23'h0};
      end else if (w_b_zero) begin
         w_spec_res     = {w_sign, 8'hFF, 23'h0};
         w_spec_divzero = 1'b1;
      end else if (w_a_zero || w_b_inf) begin
         w_spec_res = {w_sign, 31'h0};
      end else begin
         w_special = 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Sequencer
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state        <= c_ST_IDLE;
         r_guard        <= '0;
         r_tmo          <= '0;
         r_div_a        <= '0;
         r_div_b        <= '0;
         r_res_data     <= '0;
         r_flag_invalid <= 1'b0;
         r_flag_divzero <= 1'b0;
         r_flag_timeout <= 1'b0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (req_valid) begin
                  r_div_a        <= op_a;
                  r_div_b        <= op_b;
                  r_flag_timeout <= 1'b0;
                  if (w_special) begin
                     r_res_data     <= w_spec_res;
                     r_flag_invalid <= w_spec_invalid;
                     r_flag_divzero <= w_spec_divzero;
                     r_state        <= c_ST_DONE;
                  end else begin
                     r_res_data     <= '0;
                     r_flag_invalid <= 1'b0;
                     r_flag_divzero <= 1'b0;
                     r_state        <= c_ST_ISSUE;
                  end
               end
            end
            c_ST_ISSUE: begin
               r_guard <= c_GUARD_LOAD;
               r_tmo   <= '0;
               r_state <= c_ST_WAIT;
            end
            c_ST_WAIT: begin
               // While the guard runs, any ready level is the previous
               // operation's leftover and must not be taken as completion.
               if (r_guard != '0) begin
                  r_guard <= r_guard - c_GUARD_ONE;
               end else if (div_ready) begin
                  r_res_data <= div_c;
                  r_state    <= c_ST_DONE;
               end else if (r_tmo == c_TMO_LAST) begin
                  r_res_data     <= QNAN;
                  r_flag_timeout <= 1'b1;
                  r_tmo          <= '0;
                  r_state        <= c_ST_DONE;
               end else begin
                  r_tmo <= r_tmo + c_TMO_ONE;
               end
            end
            c_ST_DONE: begin
               r_tmo   <= '0;
               r_state <= c_ST_IDLE;
            end
            default: begin
               r_state <= c_ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready    = (r_state == c_ST_IDLE);
   assign busy         = (r_state != c_ST_IDLE);
   assign div_start    = (r_state == c_ST_ISSUE);
   assign res_valid    = (r_state == c_ST_DONE);
   assign div_a        = r_div_a;
   assign div_b        = r_div_b;
   assign res_data     = r_res_data;
   assign flag_invalid = r_flag_invalid;
   assign flag_divzero = r_flag_divzero;
   assign flag_timeout = r_flag_timeout;

endmodule
`default_nettype wire

// File: tb/tb_fp_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_div_seq
// Purpose  : Directed self-checking bench for fp_div_seq. A behavioural
//            divider (25-cycle latency, ready left high from the previous
//            operation for the first cycles) sits behind the DUT; a negedge
//            monitor records handshake events and cycle stamps.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_div_seq;

   localparam int DIV_LAT = 25;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        req_ready;
   logic        div_start;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic [31:0] div_c;
   logic        div_ready;
   logic        res_valid;
   logic [31:0] res_data;
   logic        flag_invalid;
   logic        flag_divzero;
   logic        flag_timeout;
   logic        busy;

   int checks = 0;
   int errors = 0;

   fp_div_seq #(
      .DIV_GUARD (2),
      .TIMEOUT   (64),
      .QNAN      (32'h7FC00000)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .op_a         (op_a),
      .op_b         (op_b),
      .div_start    (div_start),
      .div_a        (div_a),
      .div_b        (div_b),
      .div_c        (div_c),
      .div_ready    (div_ready),
      .res_valid    (res_valid),
      .res_data     (res_data),
      .flag_invalid (flag_invalid),
      .flag_divzero (flag_divzero),
      .flag_timeout (flag_timeout),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------------------------
   // Divider model. div_mode 0: normal with stale ready, 1: ready tied low.
   // ------------------------------------------------------------------------
   int          cyc = 0;
   logic        mdl_started = 1'b0;
   int          mdl_cnt = 0;
   int          div_mode = 0;
   logic [31:0] mdl_q = '0;
   logic        mdl_done;
   logic        mdl_stale;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (div_start) begin
         mdl_started <= 1'b1;
         mdl_cnt     <= 0;
      end else if (mdl_started && mdl_cnt < 1000) begin
         mdl_cnt <= mdl_cnt + 1;
      end
   end

   assign mdl_done  = mdl_started && (mdl_cnt >= DIV_LAT - 1);
   assign mdl_stale = !mdl_started || (mdl_cnt < 2);
   assign div_ready = (div_mode == 1) ? 1'b0 : (mdl_done || mdl_stale);
   assign div_c     = mdl_done ? mdl_q : 32'hDEADBEEF;

   // ------------------------------------------------------------------------
   // Event monitor
   // ------------------------------------------------------------------------
   int          acc_cyc = 0;
   int          start_cyc = 0;
   int          start_cnt = 0;
   int          res_cyc = 0;
   int          res_cnt = 0;
   logic [31:0] res_d = '0;
   logic [2:0]  res_f = '0;

   always @(negedge clk) begin
      if (req_valid && req_ready) acc_cyc <= cyc;
      if (div_start) begin
         start_cyc <= cyc;
         start_cnt <= start_cnt + 1;
      end
      if (res_valid) begin
         res_cyc <= cyc;
         res_cnt <= res_cnt + 1;
         res_d   <= res_data;
         res_f   <= {flag_invalid, flag_divzero, flag_timeout};
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   task automatic send(input logic [31:0] a, input logic [31:0] b);
      int n;
      @(posedge clk); #1;
      req_valid = 1'b1;
      op_a = a;
      op_b = b;
      n = 0;
      while (!req_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL send_accept: req_ready got %b required 1", req_ready);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_res(input int r0, input int limit, input string tag);
      int n;
      n = 0;
      while (res_cnt == r0 && n < limit) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (res_cnt == r0) begin
         checks++;
         errors++;
         $display("FAIL %s_res_timeout: no res_valid within %0d cycles", tag, limit);
      end
   endtask

   // ------------------------------------------------------------------------
   // Tests
   // ------------------------------------------------------------------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({req_ready, busy, res_valid, div_start} !== 4'b1000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b required 1000", {req_ready, busy, res_valid, div_start});
      end
      checks++;
      if ({flag_invalid, flag_divzero, flag_timeout} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: got %b required 000", {flag_invalid, flag_divzero, flag_timeout});
      end
      checks++;
      if (res_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_res_data: got %h required 00000000", res_data);
      end
      checks++;
      if ({div_a, div_b} !== 64'h0) begin
         errors++;
         $display("FAIL reset_div_ops: got %h/%h required 0/0", div_a, div_b);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_normal();
      int r0, s0;
      div_mode = 0;
      mdl_q = 32'h40400000;
      r0 = res_cnt;
      s0 = start_cnt;
      send(32'h40C00000, 32'h40000000);
      wait_res(r0, 100, "normal");
      checks++;
      if (res_d !== 32'h40400000) begin
         errors++;
         $display("FAIL normal_data: got %h required 40400000", res_d);
      end
      checks++;
      if (res_f !== 3'b000) begin
         errors++;
         $display("FAIL normal_flags: got %b required 000", res_f);
      end
      checks++;
      if (res_cyc - acc_cyc !== 27) begin
         errors++;
         $display("FAIL normal_latency: got %0d required 27", res_cyc - acc_cyc);
      end
      checks++;
      if (start_cnt - s0 !== 1) begin
         errors++;
         $display("FAIL normal_start_pulses: got %0d required 1", start_cnt - s0);
      end
      checks++;
      if ({div_a, div_b} !== {32'h40C00000, 32'h40000000}) begin
         errors++;
         $display("FAIL normal_div_ops: got %h/%h required 40c00000/40000000", div_a, div_b);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (res_cnt - r0 !== 1) begin
         errors++;
         $display("FAIL normal_res_pulses: got %0d required 1", res_cnt - r0);
      end
      checks++;
      if (res_data !== 32'h40400000) begin
         errors++;
         $display("FAIL normal_res_hold: got %h required 40400000", res_data);
      end
   endtask

   task automatic test_special();
      logic [31:0] va [7];
      logic [31:0] vb [7];
      logic [31:0] vq [7];
      logic [2:0]  vf [7];
      int r0, s0;
      // {invalid, divzero, timeout}
      va[0] = 32'h3F800000; vb[0] = 32'h00000000; vq[0] = 32'h7F800000; vf[0] = 3'b010;
      va[1] = 32'h80000000; vb[1] = 32'h00000000; vq[1] = 32'h7FC00000; vf[1] = 3'b100;
      va[2] = 32'h7F800000; vb[2] = 32'hBF800000; vq[2] = 32'hFF800000; vf[2] = 3'b000;
      va[3] = 32'h3F800000; vb[3] = 32'h7F800000; vq[3] = 32'h00000000; vf[3] = 3'b000;
      va[4] = 32'h7FC00001; vb[4] = 32'h00000000; vq[4] = 32'h7FC00000; vf[4] = 3'b100;
      va[5] = 32'h80000000; vb[5] = 32'h3F800000; vq[5] = 32'h80000000; vf[5] = 3'b000;
      va[6] = 32'hBF800000; vb[6] = 32'h80000000; vq[6] = 32'h7F800000; vf[6] = 3'b010;
      for (int i = 0; i < 7; i++) begin
         r0 = res_cnt;
         s0 = start_cnt;
         send(va[i], vb[i]);
         wait_res(r0, 20, "special");
         checks++;
         if (res_d !== vq[i]) begin
            errors++;
            $display("FAIL special%0d_data: got %h required %h", i, res_d, vq[i]);
         end
         checks++;
         if (res_f !== vf[i]) begin
            errors++;
            $display("FAIL special%0d_flags: got %b required %b", i, res_f, vf[i]);
         end
         checks++;
         if (res_cyc - acc_cyc !== 1) begin
            errors++;
            $display("FAIL special%0d_latency: got %0d required 1", i, res_cyc - acc_cyc);
         end
         checks++;
         if (start_cnt !== s0) begin
            errors++;
            $display("FAIL special%0d_no_start: got %0d pulses required 0", i, start_cnt - s0);
         end
      end
   endtask

   task automatic test_timeout();
      int r0;
      div_mode = 1;
      r0 = res_cnt;
      send(32'h3F800000, 32'h40000000);
      wait_res(r0, 300, "timeout");
      checks++;
      if (res_d !== 32'h7FC00000) begin
         errors++;
         $display("FAIL timeout_data: got %h required 7fc00000", res_d);
      end
      checks++;
      if (res_f !== 3'b001) begin
         errors++;
         $display("FAIL timeout_flags: got %b required 001", res_f);
      end
      checks++;
      if (res_cyc - start_cyc !== 67) begin
         errors++;
         $display("FAIL timeout_latency: got %0d required 67", res_cyc - start_cyc);
      end
      div_mode = 0;
   endtask

   task automatic test_reset_mid_wait();
      int r0;
      div_mode = 0;
      mdl_q = 32'h40400000;
      r0 = res_cnt;
      send(32'h40C00000, 32'h40000000);
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL rstwait_busy_before: got %b required 1", busy);
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      checks++;
      if ({busy, req_ready} !== 2'b01) begin
         errors++;
         $display("FAIL rstwait_idle_after: busy/req_ready got %b required 01", {busy, req_ready});
      end
      checks++;
      if (res_data !== 32'h0) begin
         errors++;
         $display("FAIL rstwait_res_data: got %h required 00000000", res_data);
      end
      repeat (40) @(posedge clk);
      #1;
      checks++;
      if (res_cnt !== r0) begin
         errors++;
         $display("FAIL rstwait_no_result: got %0d pulses required 0", res_cnt - r0);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL rstwait_busy_late: got %b required 0", busy);
      end
   endtask

   task automatic test_back_to_back();
      int r0, r1, n, viol, first_res;
      div_mode = 0;
      mdl_q = 32'h40000000;
      r0 = res_cnt;
      viol = 0;
      @(posedge clk); #1;
      req_valid = 1'b1;
      op_a = 32'h41200000;
      op_b = 32'h40A00000;
      n = 0;
      while (!req_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      // First pair accepted; present a different pair while busy.
      op_a = 32'h3F800000;
      op_b = 32'h00000000;
      n = 0;
      while (res_cnt == r0 && n < 100) begin
         if (req_ready) viol++;
         if (div_a !== 32'h41200000 || div_b !== 32'h40A00000) viol++;
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (res_cnt == r0) begin
         errors++;
         $display("FAIL b2b_first_timeout: no res_valid within %0d cycles", n);
      end
      checks++;
      if (viol !== 0) begin
         errors++;
         $display("FAIL b2b_backpressure: got %0d violations required 0", viol);
      end
      checks++;
      if (res_d !== 32'h40000000 || res_f !== 3'b000) begin
         errors++;
         $display("FAIL b2b_first_result: got %h/%b required 40000000/000", res_d, res_f);
      end
      first_res = res_cyc;
      r1 = res_cnt;
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_res(r1, 20, "b2b_second");
      checks++;
      if (res_d !== 32'h7F800000 || res_f !== 3'b010) begin
         errors++;
         $display("FAIL b2b_second_result: got %h/%b required 7f800000/010", res_d, res_f);
      end
      checks++;
      if (acc_cyc - first_res !== 1) begin
         errors++;
         $display("FAIL b2b_accept_gap: got %0d required 1", acc_cyc - first_res);
      end
      checks++;
      if (div_a !== 32'h3F800000 || div_b !== 32'h00000000) begin
         errors++;
         $display("FAIL b2b_second_latch: got %h/%h required 3f800000/00000000", div_a, div_b);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_normal();
      test_special();
      test_timeout();
      test_reset_mid_wait();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
